// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-side AXI read path.
package cpu_axi_pkg;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned ID_W  = 4;

  localparam logic [PTR_W-1:0] REQ_DCACHE  = 2'd0;
  localparam logic [PTR_W-1:0] REQ_UNCACHE = 2'd1;
  localparam logic [PTR_W-1:0] REQ_ICACHE  = 2'd2;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } rd_arb_state_t;

  // Round-robin successor; wraps ICache back to DCache so 3 never appears.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
    return (idx == REQ_ICACHE) ? REQ_DCACHE : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester at or after the pointer, mod 3.
module rr_picker
  import cpu_axi_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt_c,
  output logic [PTR_W-1:0] o_idx_c,
  output logic             o_valid_c
);

  logic [PTR_W-1:0] w_first;
  logic [PTR_W-1:0] w_second;
  logic [PTR_W-1:0] w_third;

  // Scan order for the current pointer.
  always_comb begin
    w_first  = REQ_DCACHE;
    w_second = REQ_UNCACHE;
    w_third  = REQ_ICACHE;
    case (i_ptr)
      REQ_UNCACHE: begin
        w_first  = REQ_UNCACHE;
        w_second = REQ_ICACHE;
        w_third  = REQ_DCACHE;
      end
      REQ_ICACHE: begin
        w_first  = REQ_ICACHE;
        w_second = REQ_DCACHE;
        w_third  = REQ_UNCACHE;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_valid_c = |i_req;
    o_idx_c   = '0;
    if (i_req[w_first]) begin
      o_idx_c = w_first;
    end else if (i_req[w_second]) begin
      o_idx_c = w_second;
    end else if (i_req[w_third]) begin
      o_idx_c = w_third;
    end
    o_gnt_c = o_valid_c ? (N_REQ'(1) << o_idx_c) : '0;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel among DCache, uncached-load and ICache requesters,
// one burst at a time, round-robin.
module axi_rd_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        req_gnt,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic                    resp_last,
  output logic [DATA_W-1:0]       resp_data,
  output logic [ID_W-1:0]         arid,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [DATA_W-1:0]       rdata,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    proto_err
);

  rd_arb_state_t    r_state;
  rd_arb_state_t    w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [N_REQ-1:0] r_owner_oh;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat;
  logic             r_proto_err;

  logic [N_REQ-1:0] w_pick_gnt;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic             w_latch;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_rready;
  logic             w_err_c;
  logic [ADDR_W-1:0] w_addr_arr [N_REQ];
  logic [LEN_W-1:0]  w_len_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_len_arr[g]  = req_len[g*LEN_W +: LEN_W];
  end

  rr_picker u_rr_picker (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt_c   (w_pick_gnt),
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

  // Next state, handshakes, and the combinational R-channel routing.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ar_hs     = 1'b0;
    w_r_hs      = 1'b0;
    w_rready    = 1'b0;
    w_err_c     = 1'b0;
    req_gnt     = '0;
    resp_valid  = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = AR;
        end
      end
      AR: begin
        w_ar_hs = arready;
        req_gnt = r_owner_oh & {N_REQ{arready}};
        if (arready) begin
          w_state_nxt = R;
        end
      end
      R: begin
        w_rready   = |(r_owner_oh & resp_ready);
        resp_valid = r_owner_oh & {N_REQ{rvalid}};
        w_r_hs     = rvalid & w_rready;
        w_err_c    = w_r_hs & ((rid != arid) ||
                               (rlast && (r_beat != r_len)) ||
                               (!rlast && (r_beat == r_len)));
        if (w_r_hs && rlast) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_owner_oh  <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_latch) begin
        r_owner    <= w_pick_idx;
        r_owner_oh <= w_pick_gnt;
        r_addr     <= w_addr_arr[w_pick_idx];
        r_len      <= w_len_arr[w_pick_idx];
      end
      // Beat counter saturates rather than wrapping on over-long bursts.
      if (w_ar_hs) begin
        r_beat <= '0;
      end else if (w_r_hs && (r_beat != '1)) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_r_hs && rlast) begin
        r_ptr <= rr_next(r_owner);
      end
      if (w_err_c) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign arvalid   = (r_state == AR);
  assign araddr    = r_addr;
  assign arid      = ID_W'(r_owner);
  assign arlen     = 8'(r_len);
  assign arsize    = SIZE_WORD;
  assign arburst   = BURST_INCR;
  assign rready    = w_rready;
  assign resp_data = rdata;
  assign resp_last = rlast;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized bursts against a request-queue model.
module tb_axi_rd_arbiter;
  import cpu_axi_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*LW-1:0] req_len;
  logic [2:0]    req_gnt;
  logic [2:0]    resp_valid;
  logic [2:0]    resp_ready;
  logic          resp_last;
  logic [DW-1:0] resp_data;
  logic [3:0]    arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [3:0]    rid;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          proto_err;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_gnt(req_gnt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_last(resp_last), .resp_data(resp_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who is waiting, what they asked for, the fairness pointer, the sticky error.
  int          m_ptr;
  logic        m_err;
  logic [2:0]  m_pend;
  logic [31:0] m_addr [3];
  logic [3:0]  m_len  [3];

  function automatic int model_pick();
    int i;
    for (int k = 0; k < 3; k++) begin
      i = (m_ptr + k) % 3;
      if (m_pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    req_valid = m_pend;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*AW +: AW] = m_addr[i];
      req_len[i*LW +: LW]  = m_len[i];
    end
  endtask

  task automatic add_req(input int i, input logic [31:0] a, input int l);
    m_pend[i] = 1'b1;
    m_addr[i] = a;
    m_len[i]  = 4'(l);
  endtask

  // One full burst starting from an IDLE cycle; leaves the bench in the following IDLE cycle.
  task automatic run_burst(input int last_beat, input bit bad_rid, input int stall_at,
                           input int stall_n, input int ar_wait, input bit rnd_ready,
                           input int abort_at, output logic [3:0] obs_id);
    int w;
    int b;
    int stall_left;
    logic [DW-1:0] d;
    logic [3:0] rid_val;
    drive_reqs();
    w = model_pick();
    obs_id = 4'hF;
    n_cmp++;
    if (w < 0) begin
      n_bad++;
      $display("FAIL burst_setup: no requester pending, got none want one");
      return;
    end
    rid_val = bad_rid ? 4'((w + 1) % 3) : 4'(w);
    #1;
    n_cmp++;
    if (arvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_gap: arvalid=%b want 0", arvalid);
    end
    @(negedge clk); #1;
    obs_id = arid;
    n_cmp++;
    if (arvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_latency: arvalid=%b want 1", arvalid);
      return;
    end
    n_cmp++;
    if (arid !== 4'(w) || arlen !== 8'(m_len[w]) || araddr !== m_addr[w]) begin
      n_bad++;
      $display("FAIL ar_fields: arid=%0d arlen=%0d araddr=%h want %0d %0d %h",
               arid, arlen, araddr, w, m_len[w], m_addr[w]);
    end
    // Requester inputs may change once latched; AR fields must not follow them.
    req_addr = {$urandom, $urandom, $urandom};
    req_len  = 12'($urandom);
    for (int c = 0; c < ar_wait; c++) begin
      #1;
      n_cmp++;
      if (req_gnt !== 3'b000 || arvalid !== 1'b1) begin
        n_bad++;
        $display("FAIL ar_hold: gnt=%b arvalid=%b want 000 1", req_gnt, arvalid);
      end
      @(negedge clk);
    end
    arready = 1'b1;
    #1;
    n_cmp++;
    if (req_gnt !== 3'(1 << w) || araddr !== m_addr[w] || arlen !== 8'(m_len[w])) begin
      n_bad++;
      $display("FAIL gnt_pulse: gnt=%b araddr=%h arlen=%0d want %b %h %0d",
               req_gnt, araddr, arlen, 3'(1 << w), m_addr[w], m_len[w]);
    end
    @(negedge clk);
    arready = 1'b0;
    m_pend[w] = 1'b0;
    drive_reqs();
    #1;
    n_cmp++;
    if (req_gnt !== 3'b000 || arvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL gnt_single: gnt=%b arvalid=%b want 000 0", req_gnt, arvalid);
    end
    stall_left = stall_n;
    b = 0;
    while (b <= last_beat) begin
      if (b == abort_at) begin
        rst = 1'b1; rvalid = 1'b1; rlast = 1'b0; resp_ready = 3'b111;
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_ptr = 0;
        m_err = 1'b0;
        n_cmp++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || resp_valid !== 3'b000 || proto_err !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_mid: arvalid=%b rready=%b resp_valid=%b proto_err=%b want 0 0 000 0",
                   arvalid, rready, resp_valid, proto_err);
        end
        n_cmp++;
        if (araddr !== '0 || arid !== 4'd0 || arlen !== 8'd0) begin
          n_bad++;
          $display("FAIL reset_mid_ar: araddr=%h arid=%0d arlen=%0d want 0 0 0", araddr, arid, arlen);
        end
        rvalid = 1'b0;
        return;
      end
      d = $urandom;
      rdata = d;
      rvalid = 1'b1;
      rlast = (b == last_beat);
      rid = rid_val;
      if (b == stall_at && stall_left > 0) begin
        resp_ready = 3'($urandom);
        resp_ready[w] = 1'b0;
        stall_left--;
      end else if (rnd_ready) begin
        resp_ready = 3'($urandom);
        resp_ready[w] = ($urandom_range(0, 2) != 0);
      end else begin
        resp_ready = 3'b111;
      end
      #1;
      n_cmp++;
      if (resp_valid !== 3'(1 << w) || rready !== resp_ready[w]) begin
        n_bad++;
        $display("FAIL r_route: resp_valid=%b rready=%b want %b %b",
                 resp_valid, rready, 3'(1 << w), resp_ready[w]);
      end
      n_cmp++;
      if (resp_data !== d || resp_last !== rlast || proto_err !== m_err) begin
        n_bad++;
        $display("FAIL r_beat%0d: data=%h last=%b proto_err=%b want %h %b %b",
                 b, resp_data, resp_last, proto_err, d, rlast, m_err);
      end
      if (resp_ready[w]) begin
        if (rid_val != 4'(w) || (rlast && b != int'(m_len[w])) || (!rlast && b == int'(m_len[w])))
          m_err = 1'b1;
        b++;
      end
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    resp_ready = 3'b111;
    m_ptr = (w + 1) % 3;
    #1;
    n_cmp++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || resp_valid !== 3'b000 || proto_err !== m_err) begin
      n_bad++;
      $display("FAIL burst_end: arvalid=%b rready=%b resp_valid=%b proto_err=%b want 0 0 000 %b",
               arvalid, rready, resp_valid, proto_err, m_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 3'($urandom);
    rvalid = 1'b1; arready = 1'b1; resp_ready = 3'b111;
    rlast = 1'b0; rid = 4'd0; rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({arvalid, rready, req_gnt, resp_valid, proto_err} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: arvalid=%b rready=%b gnt=%b resp_valid=%b proto_err=%b want all 0",
               arvalid, rready, req_gnt, resp_valid, proto_err);
    end
    n_cmp++;
    if (araddr !== '0 || arid !== 4'd0 || arlen !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_ar: araddr=%h arid=%0d arlen=%0d want 0 0 0", araddr, arid, arlen);
    end
    n_cmp++;
    if (arsize !== 3'b010 || arburst !== 2'b01) begin
      n_bad++;
      $display("FAIL ar_consts: arsize=%b arburst=%b want 010 01", arsize, arburst);
    end
    req_valid = 3'b000; rvalid = 1'b0; arready = 1'b0; rst = 1'b0;
    m_ptr = 0; m_err = 1'b0; m_pend = 3'b000;
    @(negedge clk); #1;
    n_cmp++;
    if (arvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: arvalid=%b want 0", arvalid);
    end
  endtask

  task automatic test_single();
    logic [3:0] id;
    add_req(2, 32'h1FC0_0000, 7);
    run_burst(7, 1'b0, -1, 0, 1, 1'b0, -1, id);
    n_cmp++;
    if (id !== 4'd2) begin
      n_bad++;
      $display("FAIL single_id: arid=%0d want 2", id);
    end
  endtask

  task automatic test_rr_order();
    logic [3:0] id;
    for (int i = 0; i < 3; i++) add_req(i, 32'h1000_0000 + 32'(i * 64), 0);
    for (int k = 0; k < 3; k++) begin
      run_burst(0, 1'b0, -1, 0, 0, 1'b0, -1, id);
      n_cmp++;
      if (id !== 4'(k)) begin
        n_bad++;
        $display("FAIL rr_order%0d: arid=%0d want %0d", k, id, k);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] id;
    add_req(1, 32'hA000_0040, 5);
    run_burst(5, 1'b0, 2, 3, 0, 1'b0, -1, id);
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL backpressure_err: proto_err=%b want 0", proto_err);
    end
  endtask

  task automatic test_proto_len();
    logic [3:0] id;
    add_req(0, 32'h0000_2000, 3);
    run_burst(1, 1'b0, -1, 0, 0, 1'b0, -1, id);
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL early_rlast: proto_err=%b want 1", proto_err);
    end
    add_req(2, 32'h0000_3000, 2);
    run_burst(2, 1'b0, -1, 0, 0, 1'b0, -1, id);
    n_cmp++;
    if (proto_err !== 1'b1 || id !== 4'd2) begin
      n_bad++;
      $display("FAIL err_sticky: proto_err=%b arid=%0d want 1 2", proto_err, id);
    end
  endtask

  task automatic test_rid_err();
    logic [3:0] id;
    add_req(0, 32'h0000_4000, 1);
    run_burst(1, 1'b1, -1, 0, 0, 1'b0, -1, id);
    n_cmp++;
    if (proto_err !== 1'b1 || id !== 4'd0) begin
      n_bad++;
      $display("FAIL rid_err: proto_err=%b arid=%0d want 1 0", proto_err, id);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] id;
    add_req(1, 32'h8000_1000, 7);
    run_burst(7, 1'b0, -1, 0, 0, 1'b0, 4, id);
    n_cmp++;
    if (id !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_mid_owner: arid=%0d want 1", id);
    end
    add_req(0, 32'h8000_2000, 2);
    add_req(1, 32'h8000_3000, 1);
    run_burst(2, 1'b0, -1, 0, 0, 1'b0, -1, id);
    n_cmp++;
    if (id !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_ptr: arid=%0d want 0", id);
    end
    run_burst(1, 1'b0, -1, 0, 0, 1'b0, -1, id);
  endtask

  task automatic test_random();
    logic [3:0] id;
    int w;
    int last;
    bit bad;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 3; i++)
        if (!m_pend[i] && $urandom_range(0, 1) == 1) add_req(i, $urandom, $urandom_range(0, 7));
      if (m_pend == 3'b000) add_req($urandom_range(0, 2), $urandom, $urandom_range(0, 7));
      w = model_pick();
      last = int'(m_len[w]);
      bad = 1'b0;
      if (n >= 18) begin
        if ($urandom_range(0, 2) == 0) last = $urandom_range(0, 9);
        bad = ($urandom_range(0, 3) == 0);
      end
      run_burst(last, bad, -1, 0, $urandom_range(0, 2), 1'b1, -1, id);
      n_cmp++;
      if (id !== 4'(w)) begin
        n_bad++;
        $display("FAIL rand_owner%0d: arid=%0d want %0d", n, id, w);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0; resp_ready = '0;
    arready = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    m_ptr = 0; m_err = 1'b0; m_pend = '0;
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = '0;
      m_len[i]  = '0;
    end
    test_reset();
    test_single();
    test_rr_order();
    test_backpressure();
    test_proto_len();
    test_reset();
    test_rid_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
